// File: rtl/nbcac_pkg.sv
// Shared NBCAC definitions: data/codeword widths, scheduler states and the
// tail-count helper used by the 12-to-17 bit encoder.
package nbcac_pkg;

    localparam int NBCAC_DIN_W  = 12;
    localparam int NBCAC_CODE_W = 17;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } nbcac_state_t;

    // Number of ways to append m more bits to a codeword prefix whose last
    // bit is "free" (may be followed by either value) without creating a
    // 010 or 101 pattern.  This is a Fibonacci sequence offset by two.
    // m = -1 is defined as 1: a "locked" prefix with no bits remaining is
    // one valid completion, and the locked count for m is the free count
    // for m-1.
    function automatic int fpf_tail(input int m);
        int a;
        int b;
        int t;
        a = 1;
        b = 1;
        if (m < 0) begin
            return 1;
        end
        for (int i = 0; i < m; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

endpackage

// File: rtl/nbcac_12di_encoder_core.sv
// 12-bit to 17-bit NBCAC encoder.  The 5168 17-bit words free of the
// crosstalk patterns 010 and 101 are ranked in ascending numeric order and
// the 12-bit input selects the codeword of that rank.  The rank is unpacked
// MSB first, one bit decision per codeword position, by comparing the
// remaining rank against the number of valid completions that start with 0.
module nbcac_12di_encoder_core
    import nbcac_pkg::*;
(
    input  logic [NBCAC_DIN_W-1:0]  din,
    output logic [NBCAC_CODE_W:1]   code
);

    // Walk the codeword from bit 17 down to bit 1, choosing each bit greedily.
    always_comb begin : rank_walk
        logic [12:0] rank;
        logic [12:0] cnt0;
        logic        last_bit;
        logic        locked;
        logic        b;
        rank     = {1'b0, din};
        cnt0     = '0;
        last_bit = 1'b0;
        locked   = 1'b0;
        b        = 1'b0;
        code     = '0;
        for (int p = NBCAC_CODE_W; p >= 1; p--) begin
            // Count of valid codewords continuing the prefix with a 0 here.
            if (p == NBCAC_CODE_W) begin
                cnt0 = 13'(fpf_tail(p - 1));
            end else if (!last_bit) begin
                cnt0 = 13'(fpf_tail(p - 1));
            end else if (locked) begin
                cnt0 = '0;
            end else begin
                cnt0 = 13'(fpf_tail(p - 2));
            end

            if (rank >= cnt0) begin
                b    = 1'b1;
                rank = rank - cnt0;
            end else begin
                b    = 1'b0;
            end
            code[p] = b;

            // A bit that starts a new run (after the first position) must be
            // repeated, otherwise it would sit alone between two opposites.
            if (p == NBCAC_CODE_W) begin
                locked = 1'b0;
            end else begin
                locked = (b != last_bit);
            end
            last_bit = b;
        end
    end

endmodule

// File: rtl/nbcac_tx_scheduler.sv
// NBCAC transmit scheduler: accepts NCHUNK x 12-bit payload words, encodes
// them chunk by chunk (LSB chunk first) through one shared encoder core and
// presents a registered 17-bit codeword per link transfer.  The last
// codeword stays on the wires while idle so the bus does not toggle.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no word in flight; in_ready=1, code_out holds the last codeword
//   SEND  | code_out holds chunk idx of data_buf, waiting for link_ready
module nbcac_tx_scheduler
    import nbcac_pkg::*;
#(
    parameter int NCHUNK = 4,
    parameter int CNT_W  = 16
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NBCAC_DIN_W*NCHUNK-1:0] in_data,
    output logic [NBCAC_CODE_W:1]         code_out,
    output logic                          code_valid,
    output logic                          code_first,
    output logic                          code_last,
    input  logic                          link_ready,
    output logic                          busy,
    output logic [CNT_W-1:0]              word_count
);

    localparam int               IDX_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCHUNK - 1);
    localparam logic [IDX_W:0]   LAST_NEXT = (IDX_W + 1)'(NCHUNK - 1);

    nbcac_state_t                   state;
    logic [NBCAC_DIN_W*NCHUNK-1:0]  data_buf;
    logic [IDX_W-1:0]               idx;
    logic [IDX_W:0]                 next_idx;
    logic                           last_xfer;
    logic                           accept;
    logic [NBCAC_DIN_W-1:0]         chunk_sel;
    logic [NBCAC_DIN_W-1:0]         enc_in;
    logic [NBCAC_CODE_W:1]          enc_code;

    // next_idx is one bit wider than idx so it never wraps onto chunk 0.
    assign next_idx  = {1'b0, idx} + (IDX_W + 1)'(1);
    assign last_xfer = (state == SEND) && link_ready && (idx == LAST_IDX);
    assign in_ready  = !rst && ((state == IDLE) || last_xfer);
    assign accept    = in_ready && in_valid;
    assign busy      = (state == SEND);

    // Select the buffered chunk that follows the one currently on the wires.
    always_comb begin
        chunk_sel = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (next_idx == (IDX_W + 1)'(k)) begin
                chunk_sel = data_buf[k*NBCAC_DIN_W +: NBCAC_DIN_W];
            end
        end
    end

    // A newly accepted word encodes its chunk 0 straight from in_data; the
    // result still goes through the code_out register, never to the pins.
    assign enc_in = accept ? in_data[NBCAC_DIN_W-1:0] : chunk_sel;

    nbcac_12di_encoder_core u_enc (
        .din  (enc_in),
        .code (enc_code)
    );

    // Scheduler FSM with registered codeword, framing flags and word counter.
    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= IDLE;
            data_buf   <= '0;
            idx        <= '0;
            code_out   <= '0;
            code_valid <= 1'b0;
            code_first <= 1'b0;
            code_last  <= 1'b0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state      <= SEND;
                        data_buf   <= in_data;
                        idx        <= '0;
                        code_out   <= enc_code;
                        code_valid <= 1'b1;
                        code_first <= 1'b1;
                        code_last  <= (NCHUNK == 1);
                    end
                end
                SEND: begin
                    if (link_ready) begin
                        if (idx != LAST_IDX) begin
                            idx        <= next_idx[IDX_W-1:0];
                            code_out   <= enc_code;
                            code_first <= 1'b0;
                            code_last  <= (next_idx == LAST_NEXT);
                        end else begin
                            word_count <= word_count + CNT_W'(1);
                            if (in_valid) begin
                                data_buf   <= in_data;
                                idx        <= '0;
                                code_out   <= enc_code;
                                code_valid <= 1'b1;
                                code_first <= 1'b1;
                                code_last  <= (NCHUNK == 1);
                            end else begin
                                state      <= IDLE;
                                code_valid <= 1'b0;
                                code_first <= 1'b0;
                                code_last  <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/nbcac_tx_scheduler.md
Name: nbcac_tx_scheduler

Overview:
- Streams wide payload words over a 17-wire NBCAC-coded link.
- Accepts one N×12-bit word per valid/ready handshake and slices it into 12-bit chunks, LSB chunk first.
- Sequences the chunks through a single shared nbcac_12di_encoder_core and presents one registered 17-bit codeword per transfer, with link backpressure.
- Holds the last codeword on the wires while idle, so the bus sees no transitions between transfers.

Parameters:
- NCHUNK, 4, number of 12-bit chunks per payload word; legal range 1..16.
- CNT_W, 16, width of the transferred-word counter.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  payload word available.
- in_ready  out  1  scheduler accepts the word this cycle.
- in_data  in  12*NCHUNK  payload; chunk k = in_data[12k+11:12k].
- code_out  out  17 (bits [17:1])  registered NBCAC codeword.
- code_valid  out  1  code_out holds an untransferred codeword.
- code_first  out  1  code_out is chunk 0 of a word.
- code_last  out  1  code_out is chunk NCHUNK-1 of a word.
- link_ready  in  1  link consumes code_out this cycle when code_valid=1.
- busy  out  1  state is SEND.
- word_count  out  CNT_W  count of words whose last chunk was transferred.

Behaviour:
- Reset (rst=1 at a clock edge), applied to every state including mid-word:
  - state=IDLE; code_out=0; code_valid=0; code_first=0; code_last=0; word_count=0; internal buffer and chunk index cleared.
  - Any partially sent word is discarded.
  - in_ready=0 during the reset cycle.
- State IDLE:
  - in_ready=1 (combinational, !rst).
  - On in_valid=1:
    - data_buf<=in_data; idx<=0.
    - code_out<=enc(in_data[11:0]); code_valid<=1; code_first<=1; code_last<=(NCHUNK==1).
    - Next state is SEND.
  - Latency: codeword visible the cycle after acceptance.
- State SEND with link_ready=0:
  - All outputs and registers hold; in_ready=0.
- State SEND with link_ready=1 and idx<NCHUNK-1:
  - idx<=idx+1; code_out<=enc(data_buf chunk idx+1).
  - code_first<=0; code_last<=(idx+1==NCHUNK-1).
- State SEND with link_ready=1 and idx==NCHUNK-1 (last chunk transferred):
  - word_count<=word_count+1; wraps from 2^CNT_W-1 to 0.
  - in_ready=1 this cycle (combinational).
  - If in_valid=1: load the new word exactly as in IDLE and stay in SEND. No bubble; steady-state throughput is one codeword per cycle.
  - Else: state<=IDLE; code_valid<=0; code_first<=0; code_last<=0; code_out holds its value (no bus toggling).
- in_ready is asserted only in IDLE, or in SEND on the last-chunk transfer cycle.
- in_data is sampled only at handshake; later changes are ignored.
- Encoder sharing: exactly one encoder-core instance.
  - Its input mux selects in_data[11:0] on accept, else data_buf chunk idx+1.
  - Encoder output feeds only the code_out register; there is no combinational path from in_data to code_out.
- code_valid must never drop while link_ready=0.
- code_out must not change while code_valid=1 and link_ready=0.
- idx width is clog2(NCHUNK), minimum 1.

Decomposition:
- Shared package nbcac_pkg:
  - constants NBCAC_DIN_W=12 and NBCAC_CODE_W=17;
  - state enum {IDLE, SEND}.
- Sub-module: the existing nbcac_12di_encoder_core, instantiated once.
- Chunk mux, FSM and counter stay in this module.

Test Plan:
- Reset defaults: hold rst=1 for 3 cycles with in_valid=1 → in_ready=0, code_valid=0, code_out=0, word_count=0. Release rst → in_ready=1 the next cycle.
- Chunk order and latency: link_ready=1, NCHUNK=4, single word in_data=48'h123_456_789_ABC.
  - Cycles 1..4 after accept: code_out = enc(ABC), enc(789), enc(456), enc(123), checked against the golden encoder model.
  - code_first only on cycle 1; code_last only on cycle 4.
  - Cycle 5: code_valid=0 and code_out still equals enc(123); word_count=1.
- Backpressure: deassert link_ready for 5 cycles mid-word at idx=2 → code_out, code_valid and idx frozen, in_ready=0. Resume → remaining chunks sent in order, with no chunk duplicated or dropped.
- Back-to-back words: 3 words with in_valid held high, link_ready=1 → 12 consecutive valid codewords with no gap. in_ready is high on the accept cycles 0, 4 and 8 only; word_count=3.
- Reset mid-operation: assert rst at idx=1 → the next cycle is IDLE with outputs at reset values. A following word is sent from chunk 0.
- Counter wrap: with CNT_W=4, send 17 words → word_count=1.
